// File: rtl/pll_pkg.sv
// Shared constants and elaboration helpers for the soft PLL replacement.
// Used by the clock divider top and its lock counter.
package pll_pkg;

  localparam int LockCyclesDefault = 64;

  // clog2 with a floor of one bit so degenerate ranges still get a legal vector.
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

  function automatic bit params_legal(input int clk_divide, input int high_cycles,
                                      input int phase_cycles, input int lock_cycles);
    if (clk_divide < 1) begin
      return 1'b0;
    end
    if (lock_cycles < 1) begin
      return 1'b0;
    end
    if (clk_divide >= 2) begin
      if (high_cycles < 1 || high_cycles > clk_divide - 1) begin
        return 1'b0;
      end
      if (phase_cycles < 0 || phase_cycles > clk_divide - 1) begin
        return 1'b0;
      end
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/pll_lock_counter.sv
// Saturating reset-release counter: locked_o rises LockCycles edges after reset drops
// and holds until the next reset.
module pll_lock_counter
  import pll_pkg::*;
#(
  parameter int LockCycles = LockCyclesDefault
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic locked_o
);

  localparam int CntW = cnt_width(LockCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            locked_q, locked_d;

  always_comb begin
    cnt_d    = cnt_q;
    locked_d = locked_q;
    // Counter freezes once locked so it never wraps.
    if (!locked_q) begin
      cnt_d = cnt_q + CntW'(1);
      if (cnt_q == CntW'(LockCycles - 1)) begin
        locked_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign locked_o = locked_q;

endmodule

// File: rtl/altpll_c0_gen.sv
// Soft stand-in for the vendor PLL: integer clock divider with programmable duty and
// phase (in inclk0 cycles) plus a counter-based lock indicator.
module altpll_c0_gen
  import pll_pkg::*;
#(
  parameter int CLK_DIVIDE   = 1,
  parameter int HIGH_CYCLES  = CLK_DIVIDE / 2,
  parameter int PHASE_CYCLES = 0,
  parameter int LOCK_CYCLES  = LockCyclesDefault
) (
  input  logic inclk0,
  input  logic reset,
  output logic c0,
  output logic locked
);

  if (!params_legal(CLK_DIVIDE, HIGH_CYCLES, PHASE_CYCLES, LOCK_CYCLES)) begin : g_param_fatal
    $fatal(1, "altpll_c0_gen: illegal parameters CLK_DIVIDE=%0d HIGH_CYCLES=%0d PHASE_CYCLES=%0d LOCK_CYCLES=%0d",
           CLK_DIVIDE, HIGH_CYCLES, PHASE_CYCLES, LOCK_CYCLES);
  end

  pll_lock_counter #(
    .LockCycles(LOCK_CYCLES)
  ) u_lock (
    .clk_i   (inclk0),
    .reset_i (reset),
    .locked_o(locked)
  );

  if (CLK_DIVIDE == 1) begin : g_bypass
    assign c0 = inclk0;
  end else begin : g_divide
    localparam int CntW = cnt_width(CLK_DIVIDE);
    localparam int SumW = CntW + 1;
    localparam logic [SumW-1:0] DivW    = SumW'(CLK_DIVIDE);
    localparam logic [SumW-1:0] OffsetW = SumW'(CLK_DIVIDE - PHASE_CYCLES);
    localparam logic [SumW-1:0] HighW   = SumW'(HIGH_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [SumW-1:0] sum, pos;
    logic            c0_q, c0_d;

    // cnt + offset stays below 2*CLK_DIVIDE, so one conditional subtract replaces the modulo.
    always_comb begin
      sum   = {1'b0, cnt_q} + OffsetW;
      pos   = (sum >= DivW) ? (sum - DivW) : sum;
      c0_d  = (pos < HighW);
      cnt_d = (cnt_q == CntW'(CLK_DIVIDE - 1)) ? '0 : (cnt_q + CntW'(1));
    end

    always_ff @(posedge inclk0) begin
      if (reset) begin
        cnt_q <= '0;
        c0_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        c0_q  <= c0_d;
      end
    end

    assign c0 = c0_q;
  end

endmodule

// File: tb/tb_altpll_c0_gen.sv
// Directed bench for altpll_c0_gen covering bypass, divide, phase, mid-run reset and
// single-cycle lock configurations.
module tb_altpll_c0_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1, rst3 = 1'b1, rst4 = 1'b1;
  logic c0_0, c0_1, c0_2, c0_3, c0_4;
  logic lk0, lk1, lk2, lk3, lk4;

  int errors = 0;
  int checks = 0;

  altpll_c0_gen u_byp (
    .inclk0(clk), .reset(rst0), .c0(c0_0), .locked(lk0)
  );

  altpll_c0_gen #(
    .CLK_DIVIDE(4), .HIGH_CYCLES(2), .PHASE_CYCLES(0)
  ) u_div4 (
    .inclk0(clk), .reset(rst1), .c0(c0_1), .locked(lk1)
  );

  altpll_c0_gen #(
    .CLK_DIVIDE(5), .HIGH_CYCLES(1), .PHASE_CYCLES(2)
  ) u_div5 (
    .inclk0(clk), .reset(rst2), .c0(c0_2), .locked(lk2)
  );

  altpll_c0_gen #(
    .CLK_DIVIDE(3), .HIGH_CYCLES(2), .PHASE_CYCLES(0), .LOCK_CYCLES(8)
  ) u_div3 (
    .inclk0(clk), .reset(rst3), .c0(c0_3), .locked(lk3)
  );

  altpll_c0_gen #(
    .CLK_DIVIDE(2), .HIGH_CYCLES(1), .PHASE_CYCLES(0), .LOCK_CYCLES(1)
  ) u_lk1 (
    .inclk0(clk), .reset(rst4), .c0(c0_4), .locked(lk4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({c0_1, c0_2, c0_3, c0_4} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_c0 cycle %0d: got %b expected 0000", k, {c0_1, c0_2, c0_3, c0_4});
      end
      checks++;
      if ({lk0, lk1, lk2, lk3, lk4} !== 5'b00000) begin
        errors++;
        $display("FAIL reset_locked cycle %0d: got %b expected 00000", k,
                 {lk0, lk1, lk2, lk3, lk4});
      end
    end
  endtask

  task automatic test_bypass();
    logic exp_lk;
    @(negedge clk);
    rst0 = 1'b0;
    for (int k = 1; k <= 264; k++) begin
      tick();
      exp_lk = (k >= 64);
      checks++;
      if (c0_0 !== 1'b1) begin
        errors++;
        $display("FAIL bypass_c0_high edge %0d: got %b expected 1", k, c0_0);
      end
      checks++;
      if (lk0 !== exp_lk) begin
        errors++;
        $display("FAIL bypass_locked edge %0d: got %b expected %b", k, lk0, exp_lk);
      end
      @(negedge clk);
      #1;
      checks++;
      if (c0_0 !== 1'b0) begin
        errors++;
        $display("FAIL bypass_c0_low edge %0d: got %b expected 0", k, c0_0);
      end
    end
  endtask

  task automatic test_divide4();
    logic exp [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                       1'b1, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    rst1 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (c0_1 !== exp[k-1]) begin
        errors++;
        $display("FAIL div4_c0 edge %0d: got %b expected %b", k, c0_1, exp[k-1]);
      end
    end
  endtask

  task automatic test_phase();
    logic exp [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    rst2 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (c0_2 !== exp[k-1]) begin
        errors++;
        $display("FAIL div5_phase_c0 edge %0d: got %b expected %b", k, c0_2, exp[k-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic exp_c0, exp_lk;
    @(negedge clk);
    rst3 = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      exp_c0 = (((k - 1) % 3) < 2);
      exp_lk = (k >= 8);
      checks++;
      if (c0_3 !== exp_c0) begin
        errors++;
        $display("FAIL div3_c0 edge %0d: got %b expected %b", k, c0_3, exp_c0);
      end
      checks++;
      if (lk3 !== exp_lk) begin
        errors++;
        $display("FAIL div3_locked edge %0d: got %b expected %b", k, lk3, exp_lk);
      end
    end
    @(negedge clk);
    rst3 = 1'b1;
    tick();
    checks++;
    if ({c0_3, lk3} !== 2'b00) begin
      errors++;
      $display("FAIL div3_midreset edge 20: got c0/locked %b expected 00", {c0_3, lk3});
    end
    @(negedge clk);
    rst3 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_c0 = (((k - 1) % 3) < 2);
      exp_lk = (k >= 8);
      checks++;
      if (c0_3 !== exp_c0) begin
        errors++;
        $display("FAIL div3_restart_c0 edge %0d: got %b expected %b", k, c0_3, exp_c0);
      end
      checks++;
      if (lk3 !== exp_lk) begin
        errors++;
        $display("FAIL div3_restart_locked edge %0d: got %b expected %b", k, lk3, exp_lk);
      end
    end
  endtask

  task automatic test_lock1();
    logic exp_c0;
    @(negedge clk);
    rst4 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_c0 = (k % 2 == 1);
      checks++;
      if ({c0_4, lk4} !== {exp_c0, 1'b1}) begin
        errors++;
        $display("FAIL lock1_run edge %0d: got c0/locked %b expected %b", k, {c0_4, lk4},
                 {exp_c0, 1'b1});
      end
    end
    @(negedge clk);
    rst4 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if ({c0_4, lk4} !== 2'b00) begin
        errors++;
        $display("FAIL lock1_held_reset cycle %0d: got c0/locked %b expected 00", k,
                 {c0_4, lk4});
      end
    end
    @(negedge clk);
    rst4 = 1'b0;
    tick();
    checks++;
    if ({c0_4, lk4} !== 2'b11) begin
      errors++;
      $display("FAIL lock1_relock edge 1: got c0/locked %b expected 11", {c0_4, lk4});
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_divide4();
    test_phase();
    test_reset_mid();
    test_lock1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/altpll_c0_gen.md
Name: altpll_c0_gen

Overview:
- Synthesizable clock-generation block that stands in for the vendor PLL primitive inside the PLL peripheral wrapper.
- Derives output clock c0 from reference clock inclk0 by integer division, with programmable duty cycle and phase offset counted in inclk0 cycles.
- Provides a lock indicator modelled on the wrapper's 64-cycle reset-release counter.
- The wrapper connects only inclk0 and c0; reset and locked are available for system use.

Parameters:
- CLK_DIVIDE, 1, integer divide ratio; 1 = bypass, so c0 has the same frequency as inclk0.
- HIGH_CYCLES, CLK_DIVIDE/2, inclk0 cycles per c0 period that c0 is high; legal range 1..CLK_DIVIDE-1 when CLK_DIVIDE>=2; ignored in bypass.
- PHASE_CYCLES, 0, phase delay of c0 in inclk0 cycles; legal range 0..CLK_DIVIDE-1; ignored in bypass.
- LOCK_CYCLES, 64, inclk0 rising edges after reset release before locked asserts; must be >=1.

Ports:
- inclk0  input  1  reference clock; the only clock in the block; all registers use the rising edge.
- reset   input  1  synchronous, active-high reset.
- c0      output 1  generated clock.
- locked  output 1  high once LOCK_CYCLES edges have elapsed since reset release.

Behaviour:
- Single clock domain (inclk0). Reset is synchronous and active-high. No asynchronous paths except the bypass case described below.
- Illegal parameter values: reject at elaboration with a fatal message. This applies to CLK_DIVIDE<1, HIGH_CYCLES outside range, PHASE_CYCLES outside range, and LOCK_CYCLES<1.
- Bypass (CLK_DIVIDE==1):
  - c0 = inclk0, combinational wire, unaffected by reset.
  - Lock logic still operates.
- Divide mode (CLK_DIVIDE>=2):
  - Phase counter cnt, width clog2(CLK_DIVIDE), range 0..CLK_DIVIDE-1.
  - Position pos = (cnt + CLK_DIVIDE - PHASE_CYCLES) mod CLK_DIVIDE. Constant offset, no divider in hardware.
  - At each rising edge with reset=0: c0_reg <= (pos < HIGH_CYCLES); cnt <= (cnt==CLK_DIVIDE-1) ? 0 : cnt+1.
  - c0 = c0_reg. One inclk0 cycle of latency from cnt to c0; c0 is glitch-free because it is registered.
  - Resulting c0 period = CLK_DIVIDE inclk0 cycles, with exactly HIGH_CYCLES high.
  - Reset: cnt=0, c0_reg=0.
  - With PHASE_CYCLES=0, the first edge after release sets c0=1. c0 is high after edges 1..HIGH_CYCLES and low after edges HIGH_CYCLES+1..CLK_DIVIDE, then repeats.
  - Counter wrap: CLK_DIVIDE-1 -> 0 with no skipped or duplicated state.
- Lock:
  - Saturating counter lock_cnt, width clog2(LOCK_CYCLES+1). Reset: lock_cnt=0, locked=0.
  - Each edge with reset=0 and locked=0: lock_cnt increments. When lock_cnt==LOCK_CYCLES-1, locked <= 1 on that edge.
  - Default: locked rises at the 64th edge after release.
  - Once set, locked stays 1 and lock_cnt freezes until the next reset.
- Reset mid-operation: any edge with reset=1 returns cnt, c0_reg, lock_cnt and locked to reset values, regardless of phase.
  - In divide mode, c0 drops on that edge, truncating the current high phase; this is required behaviour.
  - Sequence restarts identically after release.
- Reset held for N cycles: outputs stay at reset values throughout; no counting.
- locked is independent of c0 activity: c0 toggles before lock. Consumers gate on locked.

Decomposition:
- Shared package pll_pkg holds:
  - default LOCK_CYCLES (64);
  - a function computing the counter width (clog2, minimum 1);
  - the elaboration-time parameter-legality check.
- One natural sub-module, pll_lock_counter: saturating reset-release counter producing locked. It is reusable by the wrapper's resetrequest logic.
- Divider and phase logic stay in the top module.

Test Plan:
- Defaults (CLK_DIVIDE=1): hold reset 3 cycles, release -> c0 tracks inclk0 exactly; locked=0 through edge 63, 1 from edge 64 onward, stays 1 for 200 cycles.
- CLK_DIVIDE=4, HIGH=2, PHASE=0: release reset -> c0 after edges 1..12 = 1,1,0,0,1,1,0,0,1,1,0,0.
- CLK_DIVIDE=5, HIGH=1, PHASE=2: -> c0 after edges 1..10 = 0,0,1,0,0,0,0,1,0,0; period 5, one-cycle pulse.
- CLK_DIVIDE=3, HIGH=2, LOCK_CYCLES=8: assert reset for 1 cycle at edge 20 -> c0=0 and locked=0 on that edge; after release, the pattern restarts as after the initial reset (1,1,0,...); locked re-asserts at the 8th edge after release.
- LOCK_CYCLES=1: release reset -> locked=1 after the first edge; reset held 10 cycles -> locked=0 and c0=0 for all 10.
- Illegal HIGH_CYCLES=4 with CLK_DIVIDE=4 -> elaboration fatal.
